// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-lite read-channel arbiter.
// Master indices double as the round-robin pointer encoding.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_e;

  localparam logic  MST_IFU      = 1'b0;
  localparam logic  MST_LSU      = 1'b1;
  localparam string DBG_LOG_PATH = "axi_lite_rd_arbiter.log";

endpackage

// File: rtl/axi_lite_rd_arbiter_if.sv
// AXI-lite read-channel bundle (AR + R).
// The master modport issues addresses; the slave modport returns data.
interface axi_lite_rd_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid
  );
endinterface

// File: rtl/axi_lite_rd_arbiter_rr_arb2.sv
// Two-requester round-robin grant; purely combinational.
// On contention the requester whose index equals the pointer wins.
module rr_arb2
  import axi_lite_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_rr,
  output logic [1:0] o_gnt,
  output logic       o_gnt_idx
);

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = MST_IFU;
    unique case (i_req)
      2'b01: begin
        o_gnt     = 2'b01;
        o_gnt_idx = MST_IFU;
      end
      2'b10: begin
        o_gnt     = 2'b10;
        o_gnt_idx = MST_LSU;
      end
      2'b11: begin
        o_gnt     = (i_rr == MST_LSU) ? 2'b10 : 2'b01;
        o_gnt_idx = i_rr;
      end
      default: begin
        o_gnt     = '0;
        o_gnt_idx = MST_IFU;
      end
    endcase
  end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master to one-slave AXI-lite read arbiter: one outstanding read,
// round-robin between IFU (m0) and LSU (m1), registered slave address.
module axi_lite_rd_arbiter
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic        RR_RESET   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] m0_araddr_i,
  input  logic                  m0_arvalid_i,
  output logic                  m0_arready_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_rvalid_o,
  input  logic                  m0_rready_i,
  input  logic [ADDR_WIDTH-1:0] m1_araddr_i,
  input  logic                  m1_arvalid_i,
  output logic                  m1_arready_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_rvalid_o,
  input  logic                  m1_rready_i,
  output logic [ADDR_WIDTH-1:0] s_araddr_o,
  output logic                  s_arvalid_o,
  input  logic                  s_arready_i,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  input  logic                  s_rvalid_i,
  output logic                  s_rready_o
);

  arb_state_e            r_state;
  logic                  r_owner;
  logic                  r_rr;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic [1:0] w_gnt;
  logic       w_gnt_idx;
  logic       w_r_fire;

  rr_arb2 u_rr_arb2 (
    .i_req     ({m1_arvalid_i, m0_arvalid_i}),
    .i_rr      (r_rr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_r_fire = s_rvalid_i && s_rready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_owner <= MST_IFU;
      r_rr    <= RR_RESET;
      r_addr  <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (|w_gnt) begin
            r_addr  <= (w_gnt_idx == MST_LSU) ? m1_araddr_i : m0_araddr_i;
            r_owner <= w_gnt_idx;
            r_state <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (s_arready_i) r_state <= ARB_DATA;
        end
        ARB_DATA: begin
          if (w_r_fire) begin
            r_rr    <= ~r_owner;
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, not just after the edge.
  always_comb begin
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    m0_rvalid_o  = 1'b0;
    m1_rvalid_o  = 1'b0;
    m0_rdata_o   = '0;
    m1_rdata_o   = '0;
    s_arvalid_o  = 1'b0;
    s_rready_o   = 1'b0;
    s_araddr_o   = '0;
    if (rst_ni) begin
      s_araddr_o = r_addr;
      unique case (r_state)
        ARB_IDLE: begin
          m0_arready_o = w_gnt[0];
          m1_arready_o = w_gnt[1];
        end
        ARB_ADDR: s_arvalid_o = 1'b1;
        ARB_DATA: begin
          if (r_owner == MST_LSU) begin
            m1_rvalid_o = s_rvalid_i;
            m1_rdata_o  = s_rdata_i;
            s_rready_o  = m1_rready_i;
          end else begin
            m0_rvalid_o = s_rvalid_i;
            m0_rdata_o  = s_rdata_i;
            s_rready_o  = m0_rready_i;
          end
        end
        default: ;
      endcase
    end
  end

  a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ARB_ADDR && !s_arready_i) |=> (s_arvalid_o && s_araddr_o == $past(s_araddr_o)));

  a_owner_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state != ARB_IDLE) |=> (r_owner == $past(r_owner)));

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter: inputs change 1 ns after posedge,
// outputs are checked 1 ns later, well clear of the next edge.
module tb_axi_lite_rd_arbiter;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  axi_lite_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0 ();
  axi_lite_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1 ();
  axi_lite_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s ();

  axi_lite_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RR_RESET(1'b0)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .m0_araddr_i  (m0.araddr),
    .m0_arvalid_i (m0.arvalid),
    .m0_arready_o (m0.arready),
    .m0_rdata_o   (m0.rdata),
    .m0_rvalid_o  (m0.rvalid),
    .m0_rready_i  (m0.rready),
    .m1_araddr_i  (m1.araddr),
    .m1_arvalid_i (m1.arvalid),
    .m1_arready_o (m1.arready),
    .m1_rdata_o   (m1.rdata),
    .m1_rvalid_o  (m1.rvalid),
    .m1_rready_i  (m1.rready),
    .s_araddr_o   (s.araddr),
    .s_arvalid_o  (s.arvalid),
    .s_arready_i  (s.arready),
    .s_rdata_i    (s.rdata),
    .s_rvalid_i   (s.rvalid),
    .s_rready_o   (s.rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0.araddr = '0; m0.arvalid = 1'b0; m0.rready = 1'b0;
    m1.araddr = '0; m1.arvalid = 1'b0; m1.rready = 1'b0;
    s.arready = 1'b0; s.rdata = '0; s.rvalid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    clear_inputs();
    rst_n = 1'b0;
    m0.arvalid = 1'b1; m1.arvalid = 1'b1; s.rvalid = 1'b1; s.arready = 1'b1;
    #1;
    outs = {m0.arready, m0.rvalid, m1.arready, m1.rvalid, s.arvalid, s.rready};
    checks++; if (outs !== 6'b0) begin failures++; $display("FAIL reset_during_outs got=%b exp=000000", outs); end
    cyc();
    cyc();
    outs = {m0.arready, m0.rvalid, m1.arready, m1.rvalid, s.arvalid, s.rready};
    checks++; if (outs !== 6'b0) begin failures++; $display("FAIL reset_held_outs got=%b exp=000000", outs); end
    clear_inputs();
    rst_n = 1'b1;
    #1;
    outs = {m0.arready, m0.rvalid, m1.arready, m1.rvalid, s.arvalid, s.rready};
    checks++; if (outs !== 6'b0) begin failures++; $display("FAIL reset_after_outs got=%b exp=000000", outs); end
    checks++; if (s.araddr !== 32'h0) begin failures++; $display("FAIL reset_araddr got=%h exp=00000000", s.araddr); end
    checks++; if ({m0.rdata, m1.rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {m0.rdata, m1.rdata}); end
  endtask

  task automatic test_single_ifu();
    do_reset();
    m0.araddr = 32'h8000_0000; m0.arvalid = 1'b1; m0.rready = 1'b1; m1.rready = 1'b1; s.arready = 1'b1;
    #1;
    checks++; if ({m1.arready, m0.arready} !== 2'b01) begin failures++; $display("FAIL single_arready got=%b exp=01", {m1.arready, m0.arready}); end
    checks++; if (s.arvalid !== 1'b0) begin failures++; $display("FAIL single_arvalid_c0 got=%b exp=0", s.arvalid); end
    cyc();
    m0.arvalid = 1'b0;
    #1;
    checks++; if (s.arvalid !== 1'b1) begin failures++; $display("FAIL single_arvalid_c1 got=%b exp=1", s.arvalid); end
    checks++; if (s.araddr !== 32'h8000_0000) begin failures++; $display("FAIL single_araddr got=%h exp=80000000", s.araddr); end
    checks++; if ({m1.arready, m0.arready} !== 2'b00) begin failures++; $display("FAIL single_arready_c1 got=%b exp=00", {m1.arready, m0.arready}); end
    cyc();
    s.rvalid = 1'b1; s.rdata = 32'h0000_0413;
    #1;
    checks++; if ({m1.rvalid, m0.rvalid} !== 2'b01) begin failures++; $display("FAIL single_rvalid got=%b exp=01", {m1.rvalid, m0.rvalid}); end
    checks++; if (m0.rdata !== 32'h0000_0413) begin failures++; $display("FAIL single_rdata got=%h exp=00000413", m0.rdata); end
    checks++; if (m1.rdata !== 32'h0) begin failures++; $display("FAIL single_m1_rdata got=%h exp=00000000", m1.rdata); end
    checks++; if (s.rready !== 1'b1) begin failures++; $display("FAIL single_rready got=%b exp=1", s.rready); end
    checks++; if (s.arvalid !== 1'b0) begin failures++; $display("FAIL single_arvalid_c2 got=%b exp=0", s.arvalid); end
    cyc();
    s.rvalid = 1'b0;
    #1;
    checks++; if ({m1.rvalid, m0.rvalid, s.rready} !== 3'b000) begin failures++; $display("FAIL single_idle_after got=%b exp=000", {m1.rvalid, m0.rvalid, s.rready}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0.araddr = 32'h8000_0010; m0.arvalid = 1'b1; m0.rready = 1'b1;
    m1.araddr = 32'h8000_0100; m1.arvalid = 1'b1; m1.rready = 1'b1;
    s.arready = 1'b1;
    #1;
    checks++; if ({m1.arready, m0.arready} !== 2'b01) begin failures++; $display("FAIL simul_first_grant got=%b exp=01", {m1.arready, m0.arready}); end
    cyc();
    m0.arvalid = 1'b0;
    #1;
    checks++; if (s.araddr !== 32'h8000_0010) begin failures++; $display("FAIL simul_addr0 got=%h exp=80000010", s.araddr); end
    checks++; if (m1.arready !== 1'b0) begin failures++; $display("FAIL simul_m1_wait got=%b exp=0", m1.arready); end
    cyc();
    s.rvalid = 1'b1; s.rdata = 32'h1111_1111;
    #1;
    checks++; if ({m1.rvalid, m0.rvalid} !== 2'b01) begin failures++; $display("FAIL simul_rvalid0 got=%b exp=01", {m1.rvalid, m0.rvalid}); end
    cyc();
    s.rvalid = 1'b0;
    #1;
    checks++; if ({m1.arready, m0.arready} !== 2'b10) begin failures++; $display("FAIL simul_second_grant got=%b exp=10", {m1.arready, m0.arready}); end
    checks++; if (s.arvalid !== 1'b0) begin failures++; $display("FAIL simul_idle_arvalid got=%b exp=0", s.arvalid); end
    cyc();
    m1.arvalid = 1'b0;
    #1;
    checks++; if (s.araddr !== 32'h8000_0100) begin failures++; $display("FAIL simul_addr1 got=%h exp=80000100", s.araddr); end
    checks++; if (s.arvalid !== 1'b1) begin failures++; $display("FAIL simul_arvalid1 got=%b exp=1", s.arvalid); end
    cyc();
    s.rvalid = 1'b1; s.rdata = 32'h2222_2222;
    #1;
    checks++; if ({m1.rvalid, m0.rvalid} !== 2'b10) begin failures++; $display("FAIL simul_rvalid1 got=%b exp=10", {m1.rvalid, m0.rvalid}); end
    checks++; if (m1.rdata !== 32'h2222_2222) begin failures++; $display("FAIL simul_rdata1 got=%h exp=22222222", m1.rdata); end
    cyc();
    s.rvalid = 1'b0;
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_sel;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    do_reset();
    m0.araddr = 32'h0000_1000; m0.arvalid = 1'b1; m0.rready = 1'b1;
    m1.araddr = 32'h0000_2000; m1.arvalid = 1'b1; m1.rready = 1'b1;
    s.arready = 1'b1; s.rvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_sel  = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_addr = (i % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000;
      exp_data = 32'hA0 + 32'(i);
      s.rdata  = exp_data;
      #1;
      checks++; if ({m1.arready, m0.arready} !== exp_sel) begin failures++; $display("FAIL fair_grant[%0d] got=%b exp=%b", i, {m1.arready, m0.arready}, exp_sel); end
      cyc();
      #1;
      checks++; if (s.araddr !== exp_addr) begin failures++; $display("FAIL fair_addr[%0d] got=%h exp=%h", i, s.araddr, exp_addr); end
      cyc();
      #1;
      checks++; if ({m1.rvalid, m0.rvalid} !== exp_sel) begin failures++; $display("FAIL fair_rvalid[%0d] got=%b exp=%b", i, {m1.rvalid, m0.rvalid}, exp_sel); end
      checks++; if (((i % 2 == 1) ? m1.rdata : m0.rdata) !== exp_data) begin failures++; $display("FAIL fair_rdata[%0d] got=%h exp=%h", i, ((i % 2 == 1) ? m1.rdata : m0.rdata), exp_data); end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m1.araddr = 32'h0000_3000; m1.arvalid = 1'b1; m1.rready = 1'b0;
    s.arready = 1'b1;
    #1;
    checks++; if ({m1.arready, m0.arready} !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", {m1.arready, m0.arready}); end
    cyc();
    m1.arvalid = 1'b0;
    m0.araddr = 32'h0000_4000; m0.arvalid = 1'b1; m0.rready = 1'b1;
    #1;
    checks++; if (m0.arready !== 1'b0) begin failures++; $display("FAIL bp_m0_arready_addr got=%b exp=0", m0.arready); end
    cyc();
    s.rvalid = 1'b1; s.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({s.rready, m1.rvalid, m0.arready, s.arvalid} !== 4'b0100) begin failures++; $display("FAIL bp_stall[%0d] got=%b exp=0100", i, {s.rready, m1.rvalid, m0.arready, s.arvalid}); end
      cyc();
    end
    m1.rready = 1'b1;
    #1;
    checks++; if (s.rready !== 1'b1) begin failures++; $display("FAIL bp_release_rready got=%b exp=1", s.rready); end
    checks++; if (m1.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_rdata got=%h exp=deadbeef", m1.rdata); end
    checks++; if (m0.arready !== 1'b0) begin failures++; $display("FAIL bp_m0_arready_data got=%b exp=0", m0.arready); end
    cyc();
    s.rvalid = 1'b0;
    #1;
    checks++; if (m0.arready !== 1'b1) begin failures++; $display("FAIL bp_m0_next_grant got=%b exp=1", m0.arready); end
    m0.arvalid = 1'b0;
  endtask

  task automatic test_arready_stall();
    do_reset();
    m0.araddr = 32'h0000_5000; m0.arvalid = 1'b1; m0.rready = 1'b1;
    s.arready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      m0.araddr = 32'h0000_6000 + 32'(i);
      #1;
      checks++; if (s.arvalid !== 1'b1) begin failures++; $display("FAIL stall_arvalid[%0d] got=%b exp=1", i, s.arvalid); end
      checks++; if (s.araddr !== 32'h0000_5000) begin failures++; $display("FAIL stall_araddr[%0d] got=%h exp=00005000", i, s.araddr); end
      checks++; if (m0.arready !== 1'b0) begin failures++; $display("FAIL stall_arready[%0d] got=%b exp=0", i, m0.arready); end
      cyc();
    end
    s.arready = 1'b1;
    m0.arvalid = 1'b0;
    #1;
    checks++; if ({s.arvalid, s.araddr} !== {1'b1, 32'h0000_5000}) begin failures++; $display("FAIL stall_accept got=%h exp=100005000", {s.arvalid, s.araddr}); end
    cyc();
    s.arready = 1'b0;
    #1;
    checks++; if (s.arvalid !== 1'b0) begin failures++; $display("FAIL stall_after_accept got=%b exp=0", s.arvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // m0 read first so the rr pointer moves to LSU
    m0.araddr = 32'h0000_7000; m0.arvalid = 1'b1; m0.rready = 1'b1;
    s.arready = 1'b1;
    cyc();
    m0.arvalid = 1'b0;
    cyc();
    s.rvalid = 1'b1;
    cyc();
    s.rvalid = 1'b0;
    m1.araddr = 32'h0000_8000; m1.arvalid = 1'b1; m1.rready = 1'b1;
    cyc();
    m1.arvalid = 1'b0;
    cyc();
    #1;
    checks++; if (s.rready !== 1'b1) begin failures++; $display("FAIL mid_in_data got=%b exp=1", s.rready); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    s.rvalid = 1'b1;
    #1;
    checks++; if ({m0.arready, m0.rvalid, m1.arready, m1.rvalid, s.arvalid, s.rready} !== 6'b0) begin failures++; $display("FAIL mid_outs got=%b exp=000000", {m0.arready, m0.rvalid, m1.arready, m1.rvalid, s.arvalid, s.rready}); end
    s.rvalid = 1'b0;
    m0.arvalid = 1'b1; m1.arvalid = 1'b1;
    #1;
    checks++; if ({m1.arready, m0.arready} !== 2'b01) begin failures++; $display("FAIL mid_rr_reset got=%b exp=01", {m1.arready, m0.arready}); end
    m0.arvalid = 1'b0;
    #1;
    checks++; if ({m1.arready, m0.arready} !== 2'b10) begin failures++; $display("FAIL mid_m1_grant got=%b exp=10", {m1.arready, m0.arready}); end
    cyc();
    m1.arvalid = 1'b0;
    #1;
    checks++; if ({s.arvalid, s.araddr} !== {1'b1, 32'h0000_8000}) begin failures++; $display("FAIL mid_m1_addr got=%h exp=100008000", {s.arvalid, s.araddr}); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_ifu();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_arready_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Two-master to one-slave AXI-lite read-channel arbiter. It sits directly upstream of the DRAM AXI-lite slave.
- Master 0 is IFU instruction fetch; master 1 is LSU load.
- It grants one read at a time with round-robin fairness, registers the granted address, and routes the single data beat back to the owner.
- Write channels bypass this block: LSU connects straight to the slave's AW/W/B.

Parameters:
DATA_WIDTH, 32, read data width
ADDR_WIDTH, 32, address width
RR_RESET, 1'b0, round-robin pointer value after reset (0 = IFU preferred)

Ports:
clk_i  in  1  clock, all logic on posedge
rst_ni  in  1  synchronous, active-low reset
m0_araddr_i  in  ADDR_WIDTH  IFU read address
m0_arvalid_i  in  1  IFU address valid
m0_arready_o  out  1  IFU address accepted
m0_rdata_o  out  DATA_WIDTH  IFU read data
m0_rvalid_o  out  1  IFU data valid
m0_rready_i  in  1  IFU data ready
m1_araddr_i  in  ADDR_WIDTH  LSU read address
m1_arvalid_i  in  1  LSU address valid
m1_arready_o  out  1  LSU address accepted
m1_rdata_o  out  DATA_WIDTH  LSU read data
m1_rvalid_o  out  1  LSU data valid
m1_rready_i  in  1  LSU data ready
s_araddr_o  out  ADDR_WIDTH  slave read address (registered)
s_arvalid_o  out  1  slave address valid
s_arready_i  in  1  slave address ready
s_rdata_i  in  DATA_WIDTH  slave read data
s_rvalid_i  in  1  slave data valid
s_rready_o  out  1  slave data ready

Behaviour:
- Reset (rst_ni low at posedge): state ARB_IDLE, owner 0, rr pointer RR_RESET, address register 0. All outputs are 0 during and after reset until a grant.
- FSM ARB_IDLE:
  - Grant if any arvalid. Only one valid: grant it. Both valid: grant the master whose index equals rr.
  - The granted master's arready_o is high combinationally in this cycle; the other master's arready is 0.
  - On the grant fire: latch its araddr, latch owner, go to ARB_ADDR.
  - No arvalid: stay.
- FSM ARB_ADDR: s_arvalid_o=1, s_araddr_o = latched address, both held stable. When s_arready_i is high, go to ARB_DATA. The address must not change while waiting.
- FSM ARB_DATA:
  - Owner's rvalid_o = s_rvalid_i and rdata_o = s_rdata_i. s_rready_o = owner's rready_i.
  - The non-owner sees rvalid 0; its rdata is don't-care, driven as 0.
  - On the s_rvalid_i && s_rready_o fire: rr <= ~owner, go to ARB_IDLE.
- ARB_IDLE and ARB_ADDR: s_rready_o=0, and both masters' rvalid are 0.
- No arready to either master outside ARB_IDLE. Exactly one read is outstanding at the slave.
- Latency, with a slave that is ready immediately:
  - Master fire at cycle N.
  - s_arvalid_o high at N+1.
  - First possible owner rvalid at N+2, plus the slave's own latency.
  - Back-to-back grant is possible in the cycle after the R fire (return to IDLE costs 1 cycle).
- A master dropping arvalid before grant is tolerated; nothing is latched.
- An rvalid stall (owner rready low) holds state ARB_DATA indefinitely.
- Reset mid-transaction returns to ARB_IDLE next cycle. The in-flight slave read is abandoned; the slave shares the same reset.
- Assertions (simulation only):
  - Owner's araddr does not matter after latch.
  - s_arvalid_o never drops before s_arready_i.
  - Owner is never switched in ARB_ADDR or ARB_DATA.

Decomposition:
- Shared package axi_lite_pkg: typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_ADDR, ARB_DATA}; master index constants MST_IFU=0 and MST_LSU=1; debug log path constant.
- One natural sub-module: rr_arb2 (2-input round-robin grant from req[1:0] and rr pointer; purely combinational). The FSM and routing stay in the top.

Test Plan:
- Single IFU read: m0 araddr=0x8000_0000 with arvalid; slave returns 0x0000_0413 -> m0_arready at cycle 0; s_arvalid at cycle 1 with addr 0x8000_0000; m0_rvalid with 0x0000_0413; m1 never sees rvalid.
- Simultaneous requests after reset: m0=0x8000_0010, m1=0x8000_0100 -> IFU granted first (rr=0); LSU granted on the cycle after IFU's R fire; slave addresses appear in order 0x8000_0010, 0x8000_0100.
- Fairness over 6 back-to-back requests with both always valid -> grant order IFU, LSU, IFU, LSU, IFU, LSU.
- Owner backpressure: m1 rready low for 5 cycles while s_rvalid high -> s_rready_o low and state held; data 0xDEAD_BEEF delivered on the first cycle rready=1; m0 arready stays 0 throughout.
- Slave arready held low 3 cycles -> s_arvalid and s_araddr stable all 3 cycles even if m0 changes its araddr_i.
- rst_ni pulled low in ARB_DATA -> next cycle all valid/ready outputs are 0, rr = RR_RESET; a new m1 request after release is granted normally.
